// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the R-format/lw/sw/beq datapath: one shared memory and ALU,
// Moore strobes per state, variable-latency memory handshake, retired counter, illegal-op trap.
module multicycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_op0,
  output logic             alu_op1,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  state_t cur, nxt;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign state  = cur;
  assign halted = (cur == S_HALT);

  always_comb begin
    nxt           = cur;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op0       = 1'b0;
    alu_op1       = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        // IR and PC load on the same edge the memory completes
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        if (Op == OP_LW || Op == OP_SW) nxt = S_MEMADR;
        else if (Op == OP_RTYPE)        nxt = S_RTYPE_EX;
        else if (Op == OP_BEQ)          nxt = S_BEQ_EX;
        else                            nxt = S_HALT;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nxt       = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op0   = 1'b1;
        nxt       = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BEQ_EX: begin
        alu_src_a     = 1'b1;
        alu_op1       = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
        nxt           = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, hand sequences for the memory-wait,
// trap, counter-wrap and async-reset cases, and a randomized run against a path-list model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op0, alu_op1;
  } strb_t;

  typedef struct {
    logic [5:0] op;
    logic       mr;
    int         st;
    int         ret;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] Op = 6'h00;

  logic pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, alu_src_a, alu_op0, alu_op1, halted;
  logic [1:0] alu_src_b;
  logic [3:0] state;
  logic [15:0] retired;

  logic pc_write4, pc_write_cond4, pc_source4, i_or_d4, mem_read4, mem_write4, ir_write4;
  logic reg_dst4, mem_to_reg4, reg_write4, alu_src_a4, alu_op04, alu_op14, halted4;
  logic [1:0] alu_src_b4;
  logic [3:0] state4;
  logic [3:0] retired4;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op0(alu_op0), .alu_op1(alu_op1),
    .state(state), .retired(retired), .halted(halted)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .pc_source(pc_source4),
    .i_or_d(i_or_d4), .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op0(alu_op04), .alu_op1(alu_op14),
    .state(state4), .retired(retired4), .halted(halted4)
  );

  strb_t got, got4;
  assign got  = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op0, alu_op1};
  assign got4 = {pc_write4, pc_write_cond4, pc_source4, i_or_d4, mem_read4, mem_write4, ir_write4,
                 reg_dst4, mem_to_reg4, reg_write4, alu_src_a4, alu_src_b4, alu_op04, alu_op14};

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int n_rdd = 0, n_rw = 0, n_m2r = 0, n_mw = 0;

  // Model: current state number, remaining path of the instruction in flight, retired count
  int          m_state = 0;
  int          m_plan[$];
  int unsigned m_ret = 0;

  function automatic strb_t exp_strb(input int s, input logic mr);
    strb_t e = '0;
    case (s)
      1: begin e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.ir_write = mr; e.pc_write = mr; end
      2: e.alu_src_b = 2'd3;
      3: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
      4: begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
      5: begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      6: begin e.mem_write = 1'b1; e.i_or_d = 1'b1; end
      7: begin e.alu_src_a = 1'b1; e.alu_op0 = 1'b1; end
      8: begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      9: begin e.alu_src_a = 1'b1; e.alu_op1 = 1'b1; e.pc_write_cond = 1'b1; e.pc_source = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void model_edge(input logic mr);
    if (m_state == 0) m_state = 1;
    else if (m_state == 10) m_state = 10;
    else if ((m_state == 1 || m_state == 4 || m_state == 6) && !mr) m_state = m_state;
    else if (m_state == 1) begin
      case (Op)
        6'h00:   m_plan = '{7, 8};
        6'h23:   m_plan = '{3, 4, 5};
        6'h2B:   m_plan = '{3, 6};
        6'h04:   m_plan = '{9};
        default: m_plan = '{10};
      endcase
      m_state = 2;
    end else if (m_plan.size() == 0) begin
      m_ret++;
      m_state = 1;
    end else m_state = m_plan.pop_front();
  endfunction

  task automatic check(input string nm);
    strb_t e = exp_strb(m_state, mem_ready);
    vectors++;
    if (state !== 4'(m_state) || state4 !== 4'(m_state) || got !== e || got4 !== e ||
        retired !== m_ret[15:0] || retired4 !== m_ret[3:0] ||
        halted !== (m_state == 10) || halted4 !== (m_state == 10)) begin
      miscompares++;
      $display("FAIL %s t=%0t state got %0d/%0d want %0d strobes got %h/%h want %h retired got %0d/%0d want %0d halted got %b want %b",
               nm, $time, state, state4, m_state, got, got4, e, retired, retired4, m_ret[15:0],
               halted, (m_state == 10));
    end
  endtask

  task automatic chk_eq(input string nm, input int actual, input int want);
    vectors++;
    if (actual != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, actual, want);
    end
  endtask

  // Called one time unit after a rising edge
  task automatic cycle(input logic mr, input string nm);
    mem_ready = mr;
    #1 check(nm);
    if (mem_read && i_or_d) n_rdd++;
    if (reg_write) n_rw++;
    if (mem_to_reg) n_m2r++;
    if (mem_write) n_mw++;
    @(posedge clk);
    model_edge(mr);
    #1;
  endtask

  task automatic async_reset(input string nm);
    #2 rst_n = 1'b0;
    m_state = 0; m_ret = 0; m_plan.delete();
    #1 check(nm);
    @(posedge clk);
    #1 check(nm);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int waits, input string nm, output int clocks);
    int w = 0;
    logic mr;
    Op = op;
    clocks = 0;
    if (m_state == 0) cycle(1'b1, nm);
    do begin
      mr = 1'b1;
      if ((m_state == 4 || m_state == 6) && w < waits) begin mr = 1'b0; w++; end
      cycle(mr, nm);
      clocks++;
    end while (m_state != 1 && m_state != 10 && clocks < 50);
    if (clocks >= 50) chk_eq({nm, "_timeout"}, clocks, 0);
  endtask

  vec_t tbl[$];
  int   clocks;

  initial begin
    tbl.push_back('{6'h00, 1'b1, 0, 0});
    tbl.push_back('{6'h00, 1'b1, 1, 0});
    tbl.push_back('{6'h00, 1'b1, 2, 0});
    tbl.push_back('{6'h00, 1'b1, 7, 0});
    tbl.push_back('{6'h00, 1'b1, 8, 0});
    tbl.push_back('{6'h2B, 1'b1, 1, 1});
    tbl.push_back('{6'h2B, 1'b1, 2, 1});
    tbl.push_back('{6'h2B, 1'b1, 3, 1});
    tbl.push_back('{6'h2B, 1'b0, 6, 1});
    tbl.push_back('{6'h2B, 1'b1, 6, 1});
    tbl.push_back('{6'h04, 1'b1, 1, 2});
    tbl.push_back('{6'h04, 1'b1, 2, 2});
    tbl.push_back('{6'h04, 1'b1, 9, 2});
    tbl.push_back('{6'h00, 1'b0, 1, 3});
    tbl.push_back('{6'h00, 1'b0, 1, 3});

    // Reset state and release
    #2 check("reset");
    @(posedge clk);
    #1 check("reset_hold");
    rst_n = 1'b1;
    cycle(1'b1, "release");
    chk_eq("fetch_after_release", int'(state), 1);

    // Directed vector table: R, sw with one wait, beq, stalled fetch
    async_reset("tbl_reset");
    foreach (tbl[i]) begin
      Op = tbl[i].op;
      mem_ready = tbl[i].mr;
      #1;
      vectors++;
      if (state !== 4'(tbl[i].st) || got !== exp_strb(tbl[i].st, tbl[i].mr) ||
          retired !== 16'(tbl[i].ret)) begin
        miscompares++;
        $display("FAIL tbl[%0d] state got %0d want %0d strobes got %h want %h retired got %0d want %0d",
                 i, state, tbl[i].st, got, exp_strb(tbl[i].st, tbl[i].mr), retired, tbl[i].ret);
      end
      @(posedge clk);
      #1;
    end

    // lw with three wait cycles in MEMRD
    async_reset("lw_reset");
    cycle(1'b1, "lw_idle");
    n_rdd = 0; n_rw = 0; n_m2r = 0;
    run_instr(6'h23, 3, "lw_wait", clocks);
    chk_eq("lw_clocks", clocks, 8);
    chk_eq("lw_memrd_cycles", n_rdd, 4);
    chk_eq("lw_reg_write", n_rw, 1);
    chk_eq("lw_mem_to_reg", n_m2r, 1);
    chk_eq("lw_retired", int'(retired), 1);

    // Latencies with mem_ready tied high, sw then beq
    n_rw = 0; n_mw = 0;
    run_instr(6'h2B, 0, "sw", clocks);
    chk_eq("sw_clocks", clocks, 4);
    run_instr(6'h04, 0, "beq", clocks);
    chk_eq("beq_clocks", clocks, 3);
    chk_eq("sw_beq_no_reg_write", n_rw, 0);
    chk_eq("sw_mem_write_cycles", n_mw, 1);
    run_instr(6'h00, 0, "rtype", clocks);
    chk_eq("rtype_clocks", clocks, 4);
    chk_eq("retired_after_4", int'(retired), 4);

    // Illegal opcode trap
    run_instr(6'h3F, 0, "illegal", clocks);
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), "halt_hold");
    chk_eq("halted_set", int'(halted), 1);
    chk_eq("halt_retired", int'(retired), 4);
    async_reset("halt_clear");
    chk_eq("halted_cleared", int'(halted), 0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) run_instr(6'h00, 0, "wrap", clocks);
    chk_eq("wrap4_retired", int'(retired4), 1);
    chk_eq("wrap16_retired", int'(retired), 17);

    // Async reset in the middle of MEMRD
    Op = 6'h23;
    for (int i = 0; i < 10 && m_state != 4; i++) cycle(1'b1, "to_memrd");
    chk_eq("reached_memrd", int'(state), 4);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    m_state = 0; m_ret = 0; m_plan.delete();
    #1;
    chk_eq("memrd_rst_mem_read", int'(mem_read), 0);
    chk_eq("memrd_rst_retired", int'(retired), 0);
    check("memrd_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 1 || m_state == 0) begin
        case ($urandom_range(0, 3))
          0: Op = 6'h00;
          1: Op = 6'h23;
          2: Op = 6'h2B;
          default: Op = 6'h04;
        endcase
      end
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      else cycle(1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
